// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider.
package div_pkg;

  // Controller state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // One quotient bit is produced per RUN cycle
  localparam int DIV_ITER = 32;

  // Quotient reported for a zero divisor
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/sub.sv
// 32-bit ripple-borrow subtractor: difference = a - b - bor_in.
// bor_out is 1 when the true result is negative (a < b + bor_in).
module sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bor_in,
  output logic [WIDTH-1:0] difference,
  output logic             bor_out
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = bor_in;

  // Full-subtractor cell per bit, borrow ripples from LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign difference[i] = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bor_out = borrow[WIDTH];

endmodule

// File: rtl/divider.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU.
// Handshake: start is accepted only while idle (busy=0); the operands and
// is_signed are captured on that same edge. busy stays high until results
// are written; done pulses for exactly one cycle as quotient/remainder/
// div_by_zero update, and those outputs then hold until the next done.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             zero_flag;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             bor_out;
  logic             ok;
  logic             last_step;

  // Magnitudes of the incoming operands; 0x80000000 maps onto itself
  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_abs = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_abs = dvs_neg ? (~divisor + 1'b1) : divisor;
  end

  // Trial subtraction of the divisor from the shifted partial remainder
  assign shifted = {rem_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  sub #(.WIDTH(WIDTH)) u_sub (
    .a          (shifted),
    .b          (d_reg),
    .bor_in     (1'b0),
    .difference (diff),
    .bor_out    (bor_out)
  );

  // rem_reg[31] stands for the bit shifted out of 'shifted'; if set, the
  // 33-bit partial remainder is certainly >= divisor.
  assign ok        = rem_reg[WIDTH-1] | ~bor_out;
  assign last_step = (count == CNT_W'(DIV_ITER - 1));
  assign busy      = (state == RUN) || (state == FIX);

  // Controller and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      rem_reg     <= '0;
      dvd_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r     <= is_signed & dividend[WIDTH-1];
            q_reg     <= dvd_abs;
            d_reg     <= dvs_abs;
            dvd_raw   <= dividend;
            rem_reg   <= '0;
            count     <= '0;
            zero_flag <= (divisor == '0);
            state     <= RUN;
          end
        end
        RUN: begin
          rem_reg <= ok ? diff : shifted;
          q_reg   <= {q_reg[WIDTH-2:0], ok};
          count   <= count + 1'b1;
          if (last_step) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_flag) begin
            quotient    <= DIV0_QUOT;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= neg_q ? (~q_reg + 1'b1) : q_reg;
            remainder   <= neg_r ? (~rem_reg + 1'b1) : rem_reg;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the iterative divider: latency, signed/unsigned
// results, divide-by-zero, ignored start, back-to-back and async reset.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total;
  int bad;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one operation starting from an idle or done cycle (#1 after an edge).
  // Optionally pulses a new start with other operands at cycle 10.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] dvd,
                       input logic [31:0] dvs, input logic [31:0] exp_q,
                       input logic [31:0] exp_r, input logic exp_z,
                       input logic poke_mid);
    int n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    start = 1'b1;
    is_signed = sgn;
    dividend = dvd;
    divisor = dvs;
    @(posedge clk);
    #1;
    n = 1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = 32'h0;
    divisor = 32'h0;
    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (poke_mid && n == 10) begin
        start = 1'b1;
        is_signed = 1'b1;
        dividend = 32'h0000_1234;
        divisor = 32'h0000_0003;
      end
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (n <= 33 && (busy !== 1'b1 || done !== 1'b0)) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 32'(n), 32'd34);
    check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    check({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
    check({tag, " quot"}, quotient, exp_q);
    check({tag, " rem"}, remainder, exp_r);
    check({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, exp_z});
  endtask

  initial begin
    int quiet;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = 32'h0;
    divisor = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset quot", quotient, 32'd0);
    check("reset rem", remainder, 32'd0);
    check("reset dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("divu_100_7",  1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 1'b0);
    do_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
    do_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
    do_op("divu_5_max",  1'b0, 32'd5,         32'hFFFF_FFFF,  32'd0,         32'd5,         1'b0, 1'b0);
    do_op("divu_max_c0", 1'b0, 32'hFFFF_FFFF, 32'hC000_0000,  32'd1,         32'h3FFF_FFFF, 1'b0, 1'b0);
    do_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 1'b0);
    do_op("div_123_0",   1'b1, 32'd123,       32'd0,          32'hFFFF_FFFF, 32'd123,       1'b1, 1'b0);
    do_op("divu_9_3",    1'b0, 32'd9,         32'd3,          32'd3,         32'd0,         1'b0, 1'b0);
    do_op("ignore_start",1'b0, 32'd1000,      32'd9,          32'd111,       32'd1,         1'b0, 1'b1);
    // Back-to-back: called straight from the done cycle of the previous op
    do_op("b2b_first",   1'b0, 32'd50,        32'd8,          32'd6,         32'd2,         1'b0, 1'b0);
    do_op("b2b_second",  1'b1, 32'hFFFF_FFCE, 32'd8,          32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Async reset in the middle of cycle 15 of an operation
    start = 1'b1;
    is_signed = 1'b0;
    dividend = 32'd77;
    divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst busy", {31'b0, busy}, 32'd0);
    check("arst done", {31'b0, done}, 32'd0);
    check("arst quot", quotient, 32'd0);
    check("arst rem", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    check("arst no_done", 32'(quiet), 32'd1);
    do_op("after_rst",   1'b0, 32'd77,        32'd5,          32'd15,        32'd2,         1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
